interrupt_scheduler: RTL and testbench



---
 rtl/interrupt_pkg.sv | 23 ++
 rtl/interrupt_scheduler_edge_sync.sv | 27 ++
 rtl/interrupt_scheduler.sv | 120 ++++++++++++
 tb/tb_interrupt_scheduler.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt scheduler: FSM encoding,
// source indices into the pending vector, and the drop-counter saturating add.
package interrupt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int SRC_KEY   = 1;
  localparam int SRC_FRAME = 0;
  localparam int DROP_W    = 8;

  // Up to three losses can land in one cycle (two events plus a timeout).
  function automatic logic [DROP_W-1:0] satAdd(input logic [DROP_W-1:0] count,
                                               input logic [1:0]        inc);
    logic [DROP_W:0] sum;
    sum = {1'b0, count} + {{(DROP_W-1){1'b0}}, inc};
    return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
  endfunction

endpackage

// File: rtl/interrupt_scheduler_edge_sync.sv
// Two-flop synchroniser with rising-edge detect for an asynchronous level.
// Reset value is a parameter so a signal held high at release produces no edge.
module edge_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {2{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
    end
  end

  assign o_rise = r_sync[1] & ~r_prev;

endmodule

// File: rtl/interrupt_scheduler.sv
// Turns jump-key and frame-ready events into CPU interrupt instructions:
// pending flags, fixed priority (key over frame), valid/ack with timeout, and an issue gap.
module interrupt_scheduler
  import interrupt_pkg::*;
#(
  parameter logic [31:0] KEY_INSTR   = 32'h0,
  parameter logic [31:0] FRAME_INSTR = 32'h0,
  parameter int          GAP_CYCLES  = 4,
  parameter int          TIMEOUT     = 64
) (
  input  logic              proc_clk,
  input  logic              reset,
  input  logic              frame_rt_clk,
  input  logic              jump_key,
  input  logic              irq_ack,
  output logic [31:0]       interrupt_instruction,
  output logic              irq_valid,
  output logic [1:0]        pending,
  output logic [DROP_W-1:0] dropped_count
);

  localparam int MAX_CNT = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_timer;
  logic [1:0]        r_pend;
  logic [1:0]        r_jumpSync;
  logic [31:0]       r_instr;
  logic              r_valid;
  logic [DROP_W-1:0] r_dropped;

  logic       w_frameTick;
  logic [1:0] w_evt;
  logic [1:0] w_grant;
  logic [1:0] w_drop;
  logic       w_expire;
  logic       w_timeout;
  logic [1:0] w_dropInc;

  edge_sync #(.RESET_VAL(1'b1)) uFrameSync (
    .i_clk   (proc_clk),
    .i_reset (reset),
    .i_async (frame_rt_clk),
    .o_rise  (w_frameTick)
  );

  always_ff @(posedge proc_clk) begin
    if (reset) r_jumpSync <= 2'b11;
    else       r_jumpSync <= {r_jumpSync[0], jump_key};
  end

  // A grant clearing a flag in the same cycle an event sets it counts as a fresh set, not a drop.
  always_comb begin
    w_evt            = '0;
    w_evt[SRC_FRAME] = w_frameTick;
    w_evt[SRC_KEY]   = w_frameTick & r_jumpSync[1];
    w_grant          = '0;
    if (r_state == ST_IDLE) begin
      if (r_pend[SRC_KEY])        w_grant[SRC_KEY]   = 1'b1;
      else if (r_pend[SRC_FRAME]) w_grant[SRC_FRAME] = 1'b1;
    end
    w_drop    = w_evt & r_pend & ~w_grant;
    w_expire  = (r_timer + 1'b1) == CNT_W'(TIMEOUT);
    w_timeout = (r_state == ST_ISSUE) && !irq_ack && w_expire;
    w_dropInc = {1'b0, w_drop[SRC_KEY]} + {1'b0, w_drop[SRC_FRAME]} + {1'b0, w_timeout};
  end

  always_ff @(posedge proc_clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_timer   <= '0;
      r_pend    <= '0;
      r_instr   <= '0;
      r_valid   <= 1'b0;
      r_dropped <= '0;
    end else begin
      r_pend    <= (r_pend & ~w_grant) | w_evt;
      r_dropped <= satAdd(r_dropped, w_dropInc);
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            r_valid <= 1'b1;
            r_instr <= w_grant[SRC_KEY] ? KEY_INSTR : FRAME_INSTR;
            r_timer <= '0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (irq_ack || w_expire) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_timer <= '0;
            r_state <= (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_GAP: begin
          if ((r_timer + 1'b1) == CNT_W'(GAP_CYCLES)) begin
            r_timer <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: begin
          r_timer <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign interrupt_instruction = r_instr;
  assign irq_valid             = r_valid;
  assign pending               = r_pend;
  assign dropped_count         = r_dropped;

endmodule

// File: tb/tb_interrupt_scheduler.sv
// Directed bench for interrupt_scheduler: reset, single/dual issue ordering,
// ack timeout, drop counting with saturation, and reset during an issue.
module tb_interrupt_scheduler;

  localparam logic [31:0] KEY_W   = 32'hCAFE_0001;
  localparam logic [31:0] FRAME_W = 32'hF00D_0002;

  logic        proc_clk;
  logic        reset;
  logic        frame_rt_clk;
  logic        jump_key;
  logic        irq_ack;
  logic [31:0] interrupt_instruction;
  logic        irq_valid;
  logic [1:0]  pending;
  logic [7:0]  dropped_count;

  int testsRun  = 0;
  int failCount = 0;

  interrupt_scheduler #(
    .KEY_INSTR   (KEY_W),
    .FRAME_INSTR (FRAME_W),
    .GAP_CYCLES  (4),
    .TIMEOUT     (64)
  ) dut (
    .proc_clk              (proc_clk),
    .reset                 (reset),
    .frame_rt_clk          (frame_rt_clk),
    .jump_key              (jump_key),
    .irq_ack               (irq_ack),
    .interrupt_instruction (interrupt_instruction),
    .irq_valid             (irq_valid),
    .pending               (pending),
    .dropped_count         (dropped_count)
  );

  initial proc_clk = 1'b0;
  always #5 proc_clk = ~proc_clk;

  // Drive inputs, then advance the given number of clocks and settle 1 ns past the edge.
  task automatic applyStimulus(input logic frame, input logic jump, input logic ack, input int cycles);
    frame_rt_clk = frame;
    jump_key     = jump;
    irq_ack      = ack;
    repeat (cycles) @(posedge proc_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    logic found;
    int   expDrop [3];
    expDrop = '{0, 2, 4};

    // Reset with frame_rt_clk already high must not create a tick.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("rst_valid", {31'b0, irq_valid}, 32'd0);
    checkOutput("rst_instr", interrupt_instruction, 32'd0);
    checkOutput("rst_pending", {30'b0, pending}, 32'd0);
    checkOutput("rst_dropped", {24'b0, dropped_count}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("rel_valid_low", {31'b0, irq_valid}, 32'd0);
    end
    checkOutput("rel_dropped", {24'b0, dropped_count}, 32'd0);

    // Single frame event: valid appears on the 4th edge after the rise.
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 3);
    checkOutput("f_lat3_valid", {31'b0, irq_valid}, 32'd0);
    checkOutput("f_lat3_pending", {30'b0, pending}, 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("f_valid", {31'b0, irq_valid}, 32'd1);
    checkOutput("f_instr", interrupt_instruction, FRAME_W);
    checkOutput("f_pending", {30'b0, pending}, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkOutput("f_hold_instr", interrupt_instruction, FRAME_W);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    checkOutput("f_ack_valid", {31'b0, irq_valid}, 32'd0);
    checkOutput("f_ack_instr", interrupt_instruction, 32'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1);
      checkOutput("f_gap_valid", {31'b0, irq_valid}, 32'd0);
    end

    // Frame plus key: key first, frame after ack and gap.
    applyStimulus(1'b0, 1'b1, 1'b0, 4);
    applyStimulus(1'b1, 1'b1, 1'b0, 3);
    checkOutput("kf_pending11", {30'b0, pending}, 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("kf_key_valid", {31'b0, irq_valid}, 32'd1);
    checkOutput("kf_key_instr", interrupt_instruction, KEY_W);
    checkOutput("kf_pending01", {30'b0, pending}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("kf_key_ack", {31'b0, irq_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("kf_gap_valid", {31'b0, irq_valid}, 32'd0);
    checkOutput("kf_gap_pending", {30'b0, pending}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("kf_frame_valid", {31'b0, irq_valid}, 32'd1);
    checkOutput("kf_frame_instr", interrupt_instruction, FRAME_W);
    checkOutput("kf_pending00", {30'b0, pending}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);
    checkOutput("kf_frame_ack", {31'b0, irq_valid}, 32'd0);

    // No ack: issue abandoned after 64 valid cycles, counted as one drop.
    applyStimulus(1'b0, 1'b1, 1'b0, 6);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("to_valid", {31'b0, irq_valid}, 32'd1);
    checkOutput("to_instr", interrupt_instruction, KEY_W);
    checkOutput("to_dropped0", {24'b0, dropped_count}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 63);
    checkOutput("to_last_valid", {31'b0, irq_valid}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("to_expired", {31'b0, irq_valid}, 32'd0);
    checkOutput("to_dropped1", {24'b0, dropped_count}, 32'd1);
    checkOutput("to_pending", {30'b0, pending}, 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 4);
    checkOutput("to_gap_valid", {31'b0, irq_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkOutput("to_next_instr", interrupt_instruction, FRAME_W);
    applyStimulus(1'b1, 1'b1, 1'b1, 1);

    // Three rises with key held during one issue: 2nd and 3rd drop both sources.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 2);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 4);
    checkOutput("dr_issue_instr", interrupt_instruction, FRAME_W);
    checkOutput("dr_issue_pending", {30'b0, pending}, 32'd0);
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
      checkOutput("dr_pending", {30'b0, pending}, 32'd3);
      checkOutput("dr_count", {24'b0, dropped_count}, expDrop[r]);
    end
    checkOutput("dr_still_valid", {31'b0, irq_valid}, 32'd1);

    // Keep losing events until the counter has long since saturated.
    for (int r = 0; r < 250; r++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
      applyStimulus(1'b1, 1'b1, 1'b0, 3);
    end
    checkOutput("sat_dropped", {24'b0, dropped_count}, 32'd255);

    // Reset during a live issue discards it and clears everything.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (irq_valid) found = 1'b1;
      else applyStimulus(1'b1, 1'b1, 1'b0, 1);
    end
    checkOutput("mid_wait_valid", {31'b0, found}, 32'd1);
    reset = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    reset = 1'b0;
    checkOutput("mid_valid", {31'b0, irq_valid}, 32'd0);
    checkOutput("mid_instr", interrupt_instruction, 32'd0);
    checkOutput("mid_pending", {30'b0, pending}, 32'd0);
    checkOutput("mid_dropped", {24'b0, dropped_count}, 32'd0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkOutput("mid_no_reissue", {31'b0, irq_valid}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
